// File: rtl/rele_pkg.sv
// Shared definitions for the thermostat relay scheduler: FSM state encoding
// and the temperature scale used by temp/setpoint.
package rele_pkg;

  typedef enum logic [1:0] {
    OFF_WAIT  = 2'd0,
    OFF_READY = 2'd1,
    ON_WAIT   = 2'd2,
    ON_READY  = 2'd3
  } state_e;

  // One temperature LSB in milli-degrees Celsius (0.5 degC).
  localparam int TEMP_LSB_MDEGC = 500;

endpackage

// File: rtl/rele_sched_ctrl_if.sv
// Sensor/setpoint inputs and relay-control outputs of the scheduler.
interface rele_sched_ctrl_if #(
  parameter int TW = 8
);
  logic [TW-1:0] temp;
  logic          temp_valid;
  logic [TW-1:0] setpoint;
  logic          inhibit;
  logic          rele_en;
  logic          rele_clr;
  logic          heat_on;
  logic          sensor_fault;
  logic [1:0]    state;

  modport master (
    output temp, temp_valid, setpoint, inhibit,
    input  rele_en, rele_clr, heat_on, sensor_fault, state
  );

  modport slave (
    input  temp, temp_valid, setpoint, inhibit,
    output rele_en, rele_clr, heat_on, sensor_fault, state
  );
endinterface

// File: rtl/hold_timer.sv
// Up-counter with synchronous clear that saturates at a runtime limit;
// last flags the cycle whose increment reaches the limit.
module hold_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] limit,
  output logic          last
);

  logic [CW-1:0] count;
  logic [CW:0]   count_inc;

  assign count_inc = {1'b0, count} + 1'b1;
  assign last      = (count_inc == {1'b0, limit});

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count != limit) begin
      count <= count_inc[CW-1:0];
    end
  end

endmodule

// File: rtl/rele_sched_ctrl.sv
// Thermostat scheduler: hysteresis demand, min on/off hold and sensor
// watchdog, issuing one-cycle en/clr pulses to the relay FSM.
//
// state     | meaning
// OFF_WAIT  | relay off, minimum-off hold running, demand ignored
// OFF_READY | relay off, waiting for heat demand without inhibit/fault
// ON_WAIT   | relay on, minimum-on hold running, only kill turns it off
// ON_READY  | relay on, waiting for upper threshold or kill
module rele_sched_ctrl
  import rele_pkg::*;
#(
  parameter int TW      = 8,
  parameter int HYST    = 2,
  parameter int CW      = 16,
  parameter int MIN_ON  = 1000,
  parameter int MIN_OFF = 1000,
  parameter int TIMEOUT = 50000
) (
  input logic               clk,
  input logic               rst,
  rele_sched_ctrl_if.slave  bus
);

  localparam int TWX = TW + 1;
  localparam logic [TW:0]   HYST_X    = TWX'(HYST);
  localparam logic [CW-1:0] MIN_ON_C  = CW'(MIN_ON);
  localparam logic [CW-1:0] MIN_OFF_C = CW'(MIN_OFF);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  state_e        state_q;
  logic          en_q, clr_q, heat_q, fault_q;
  logic [TW:0]   temp_x, sp_x;
  logic          dem_on, dem_off, kill;
  logic          go_on, go_off;
  logic          hold_last, wd_last;
  logic [CW-1:0] hold_limit;

  // Widened by one bit so temp+HYST and setpoint+HYST cannot wrap.
  assign temp_x  = {1'b0, bus.temp};
  assign sp_x    = {1'b0, bus.setpoint};
  assign dem_on  = bus.temp_valid && ((temp_x + HYST_X) < sp_x);
  assign dem_off = bus.temp_valid && (temp_x >= (sp_x + HYST_X));
  assign kill    = bus.inhibit || fault_q;

  assign go_on  = (state_q == OFF_READY) && dem_on && !kill;
  assign go_off = ((state_q == ON_WAIT) && kill) ||
                  ((state_q == ON_READY) && (dem_off || kill));

  assign hold_limit = state_q[1] ? MIN_ON_C : MIN_OFF_C;

  hold_timer #(.CW(CW)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clr   (go_on || go_off),
    .limit (hold_limit),
    .last  (hold_last)
  );

  hold_timer #(.CW(CW)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.temp_valid),
    .limit (TIMEOUT_C),
    .last  (wd_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF_WAIT;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      heat_q  <= 1'b0;
    end else begin
      en_q  <= go_on;
      clr_q <= go_off;
      if (go_on) begin
        heat_q <= 1'b1;
      end else if (go_off) begin
        heat_q <= 1'b0;
      end
      case (state_q)
        OFF_WAIT:  if (hold_last) state_q <= OFF_READY;
        OFF_READY: if (go_on) state_q <= ON_WAIT;
        ON_WAIT: begin
          if (go_off) begin
            state_q <= OFF_WAIT;
          end else if (hold_last) begin
            state_q <= ON_READY;
          end
        end
        ON_READY:  if (go_off) state_q <= OFF_WAIT;
        default:   state_q <= OFF_WAIT;
      endcase
    end
  end

  // A sample on the cycle the watchdog would expire takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (bus.temp_valid) begin
      fault_q <= 1'b0;
    end else if (wd_last) begin
      fault_q <= 1'b1;
    end
  end

  assign bus.state        = state_q;
  assign bus.rele_en      = en_q;
  assign bus.rele_clr     = clr_q;
  assign bus.heat_on      = heat_q;
  assign bus.sensor_fault = fault_q;

endmodule

// File: tb/tb_rele_sched_ctrl.sv
// Scenario tasks plus randomized run, checked against a cycle-level
// behavioural model of the scheduling rules.
module tb_rele_sched_ctrl;

  localparam int MIN_ON  = 4;
  localparam int MIN_OFF = 3;
  localparam int HYST    = 2;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: relay on/off, cycles completed in current phase, cycles since last sample.
  bit m_heat, m_en, m_clr, m_fault;
  int m_time, m_age;

  rele_sched_ctrl_if #(.TW(8)) bus ();

  rele_sched_ctrl #(
    .TW(8), .HYST(HYST), .CW(16),
    .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit kill, don, doff, ready;
    int t, sp;
    if (rst) begin
      m_heat = 0; m_time = 0; m_age = 0; m_fault = 0; m_en = 0; m_clr = 0;
      return;
    end
    t    = int'(bus.temp);
    sp   = int'(bus.setpoint);
    kill = bus.inhibit || m_fault;
    don  = bus.temp_valid && (t + HYST < sp);
    doff = bus.temp_valid && (t >= sp + HYST);
    m_en = 0; m_clr = 0;
    if (!m_heat) begin
      ready = (m_time >= MIN_OFF);
      if (ready && don && !kill) begin
        m_heat = 1; m_time = 0; m_en = 1;
      end else m_time++;
    end else begin
      ready = (m_time >= MIN_ON);
      if ((!ready && kill) || (ready && (doff || kill))) begin
        m_heat = 0; m_time = 0; m_clr = 1;
      end else m_time++;
    end
    if (bus.temp_valid) begin
      m_age = 0; m_fault = 0;
    end else begin
      if (m_age < TIMEOUT) m_age++;
      if (m_age == TIMEOUT) m_fault = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [5:0] got_v();
    return {bus.state, bus.heat_on, bus.rele_en, bus.rele_clr, bus.sensor_fault};
  endfunction

  function automatic logic [5:0] exp_v();
    logic [1:0] st;
    st[1] = m_heat;
    st[0] = m_heat ? (m_time >= MIN_ON) : (m_time >= MIN_OFF);
    return {st, m_heat, m_en, m_clr, m_fault};
  endfunction

  task automatic set_in(input int t, input int sp, input bit tv, input bit inh);
    bus.temp = 8'(t); bus.setpoint = 8'(sp); bus.temp_valid = tv; bus.inhibit = inh;
  endtask

  task automatic reach(input logic [1:0] target, input int budget);
    int k = 0;
    set_in(30, 40, 1, 0);
    while (bus.state !== target && k < budget) begin
      tick(); k++;
    end
    n_tests++;
    if (bus.state !== target) begin
      n_fail++; $display("FAIL reach_state got=%0d want=%0d", bus.state, target);
    end
  endtask

  task automatic test_reset();
    rst = 1; set_in(0, 0, 0, 0);
    tick(); tick();
    n_tests++;
    if (got_v() !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=000000", got_v());
    end
  endtask

  task automatic test_power_up();
    logic [1:0] exp_st[4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    set_in(30, 40, 1, 0);
    rst = 1; tick(); rst = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (bus.state !== exp_st[i-1] || bus.rele_en !== (i == 4) || bus.heat_on !== (i == 4)) begin
        n_fail++;
        $display("FAIL pwr_seq cyc%0d got st=%0d en=%b heat=%b want st=%0d en/heat=%b",
                 i, bus.state, bus.rele_en, bus.heat_on, exp_st[i-1], (i == 4));
      end
      n_tests++;
      if (got_v() !== exp_v()) begin
        n_fail++; $display("FAIL pwr_model cyc%0d got=%b want=%b", i, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_hysteresis();
    int temps[5] = '{41, 42, 42, 38, 37};
    int waits[5] = '{1, 1, 3, 1, 1};
    logic [1:0] st_want[5] = '{2'd3, 2'd0, 2'd1, 2'd1, 2'd2};
    reach(2'd3, 10);
    for (int s = 0; s < 5; s++) begin
      set_in(temps[s], 40, 1, 0);
      for (int w = 0; w < waits[s]; w++) begin
        tick();
        n_tests++;
        if (got_v() !== exp_v()) begin
          n_fail++; $display("FAIL hyst_model t=%0d got=%b want=%b", temps[s], got_v(), exp_v());
        end
      end
      n_tests++;
      if (bus.state !== st_want[s] || bus.rele_clr !== (s == 1) || bus.rele_en !== (s == 4)) begin
        n_fail++;
        $display("FAIL hyst_step t=%0d got st=%0d clr=%b en=%b want st=%0d", temps[s],
                 bus.state, bus.rele_clr, bus.rele_en, st_want[s]);
      end
    end
  endtask

  task automatic test_min_on();
    int clr_cnt = 0, clr_at = 0;
    set_in(60, 40, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.rele_clr === 1'b1) begin clr_cnt++; clr_at = i; end
      n_tests++;
      if (got_v() !== exp_v()) begin
        n_fail++; $display("FAIL minon_model cyc%0d got=%b want=%b", i, got_v(), exp_v());
      end
    end
    n_tests++;
    if (clr_cnt != 1 || clr_at != 5) begin
      n_fail++; $display("FAIL minon_clr got count=%0d at=%0d want count=1 at=5", clr_cnt, clr_at);
    end
  endtask

  task automatic test_inhibit();
    int en_cnt = 0;
    reach(2'd2, 20);
    tick();
    set_in(20, 40, 1, 1);
    tick();
    n_tests++;
    if (bus.rele_clr !== 1'b1 || bus.state !== 2'd0 || got_v() !== exp_v()) begin
      n_fail++; $display("FAIL inhibit_clr got=%b want=%b", got_v(), exp_v());
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rele_en === 1'b1) en_cnt++;
    end
    n_tests++;
    if (en_cnt != 0 || bus.state !== 2'd1) begin
      n_fail++; $display("FAIL inhibit_hold got en=%0d st=%0d want en=0 st=1", en_cnt, bus.state);
    end
    bus.inhibit = 0;
    tick();
    n_tests++;
    if (bus.rele_en !== 1'b1 || got_v() !== exp_v()) begin
      n_fail++; $display("FAIL inhibit_release got=%b want=%b", got_v(), exp_v());
    end
  endtask

  task automatic test_watchdog();
    reach(2'd3, 10);
    bus.temp_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_tests++;
      if (bus.sensor_fault !== (i == 20) || bus.heat_on !== 1'b1) begin
        n_fail++; $display("FAIL wdog_expire cyc%0d got fault=%b heat=%b", i, bus.sensor_fault, bus.heat_on);
      end
    end
    tick();
    n_tests++;
    if (bus.rele_clr !== 1'b1 || bus.heat_on !== 1'b0 || got_v() !== exp_v()) begin
      n_fail++; $display("FAIL wdog_clr got=%b want=%b", got_v(), exp_v());
    end
    set_in(45, 40, 1, 0);
    tick();
    n_tests++;
    if (bus.sensor_fault !== 1'b0) begin
      n_fail++; $display("FAIL wdog_recover got fault=%b want 0", bus.sensor_fault);
    end
    // Strobe on cycle 19, then on exactly cycle 20 (sample wins the tie).
    for (int gap = 19; gap <= 20; gap++) begin
      bus.temp_valid = 0;
      for (int i = 1; i < gap; i++) tick();
      bus.temp_valid = 1; tick();
      bus.temp_valid = 0; tick(); tick();
      n_tests++;
      if (bus.sensor_fault !== 1'b0 || got_v() !== exp_v()) begin
        n_fail++; $display("FAIL wdog_late_strobe gap%0d got=%b want=%b", gap, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_reset_mid();
    int clr_cnt = 0;
    reach(2'd3, 30);
    rst = 1; tick(); rst = 0;
    n_tests++;
    if (got_v() !== 6'b0) begin
      n_fail++; $display("FAIL midrst_outputs got=%b want=000000", got_v());
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (bus.rele_clr === 1'b1) clr_cnt++;
      n_tests++;
      if (bus.state !== ((i == 3) ? 2'd1 : 2'd0)) begin
        n_fail++; $display("FAIL midrst_hold cyc%0d got st=%0d", i, bus.state);
      end
    end
    n_tests++;
    if (clr_cnt != 0) begin
      n_fail++; $display("FAIL midrst_clr got count=%0d want 0", clr_cnt);
    end
  endtask

  task automatic test_random();
    int sp = 40, gap = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 5) sp = 30 + int'($urandom_range(20));
      if (gap == 0 && $urandom_range(99) < 2) gap = 15 + int'($urandom_range(10));
      bus.setpoint = 8'(sp);
      bus.temp = 8'(sp + int'($urandom_range(8)) - 4);
      if (gap > 0) begin
        bus.temp_valid = 0; gap--;
      end else bus.temp_valid = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 4) bus.inhibit = ~bus.inhibit;
      rst = ($urandom_range(999) < 3);
      tick();
      n_tests++;
      if (got_v() !== exp_v()) begin
        n_fail++; $display("FAIL random cyc%0d got=%b want=%b", i, got_v(), exp_v());
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_hysteresis();
    test_min_on();
    test_inhibit();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rele_sched_ctrl.md
# rele_sched_ctrl

Thermostat scheduler that drives the heating relay FSM (`fsm_rele`) through its `en`/`clr` inputs. It compares sampled temperature against a setpoint with hysteresis and enforces minimum on and minimum off hold times (anti-short-cycle). A sensor watchdog forces the relay off when temperature samples stop arriving. It sits between the temperature acquisition path and the relay FSM.

## Interface
- `TW`, 8: temperature/setpoint width, unsigned, 0.5 °C per LSB
- `HYST`, 2: hysteresis half-band in LSBs
- `CW`, 16: hold/watchdog counter width
- `MIN_ON`, 1000: minimum relay-on time in cycles, legal range 1..2^CW-1
- `MIN_OFF`, 1000: minimum relay-off time in cycles, legal range 1..2^CW-1
- `TIMEOUT`, 50000: cycles without `temp_valid` before a sensor fault, at least 1
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `temp`  in  TW  measured temperature; sampled only when `temp_valid`=1
- `temp_valid`  in  1  one-cycle strobe marking a new sample
- `setpoint`  in  TW  target temperature; used only on `temp_valid` cycles
- `inhibit`  in  1  level; manual/safety off request
- `rele_en`  out  1  one-cycle pulse to the relay FSM `en`
- `rele_clr`  out  1  one-cycle pulse to the relay FSM `clr`
- `heat_on`  out  1  high while the scheduler holds the relay on
- `sensor_fault`  out  1  watchdog expired, no sample since
- `state`  out  2  current FSM state, for debug/LEDs

## Operation
- **States:** OFF_WAIT=0, OFF_READY=1, ON_WAIT=2, ON_READY=3.
- **Demand terms**, computed at TW+1 bits so there is no wrap:
  - `dem_on` = `temp_valid` & (temp+HYST < setpoint)
  - `dem_off` = `temp_valid` & (temp >= setpoint+HYST)
- `kill` = `inhibit` | `sensor_fault`.
- **OFF_WAIT:** hold counter runs. After exactly MIN_OFF cycles in this state, go to OFF_READY. Demand is ignored here.
- **OFF_READY:** if `dem_on` & !`kill`, go to ON_WAIT, pulse `rele_en` and clear the hold counter. Otherwise stay.
- **ON_WAIT:** hold counter runs. If `kill`, go immediately to OFF_WAIT and pulse `rele_clr`; safety overrides the minimum-on time. Otherwise, after exactly MIN_ON cycles, go to ON_READY.
- **ON_READY:** if `dem_off` | `kill`, go to OFF_WAIT and pulse `rele_clr`.
- Every entry to OFF_WAIT or ON_WAIT clears the hold counter.
- `rele_en` and `rele_clr` are never high in the same cycle. Each pulse is exactly one cycle wide, once per transition.
- `heat_on` = state is ON_WAIT or ON_READY.
- **Watchdog:**
  - Counter is cleared by `temp_valid` and saturates at TIMEOUT.
  - `sensor_fault` sets when the counter reaches TIMEOUT.
  - `sensor_fault` clears on the cycle after the next `temp_valid`.
  - A sample arriving on the same cycle the counter would reach TIMEOUT wins: no fault is raised.
- Between the two thresholds (the hysteresis band) the state is held.
- Setpoint changes take effect at the next `temp_valid`.

## Timing
- **Reset values:**
  - state=OFF_WAIT, hold counter=0, watchdog counter=0
  - `rele_en`=0, `rele_clr`=0, `heat_on`=0, `sensor_fault`=0
- After reset the relay is held off for MIN_OFF cycles. This covers power-up anti-short-cycle.
- All outputs are registered. A decision sampled at edge N shows the new `state`/`heat_on` and the `rele_en`/`rele_clr` pulse during cycle N..N+1.
- Relay FSM output follows one further cycle after the pulse.
- Asserting reset mid-operation does not pulse `rele_clr`. Reset of the relay FSM itself is the system's responsibility; both share `rst`.
- `inhibit` is level-sensitive. While it is asserted in OFF_READY, demand is ignored. After deassertion, the first `dem_on` turns the relay on.

## Structure
- Shared package `rele_pkg`: state encodings (OFF_WAIT..ON_READY) and the 0.5 °C LSB constant.
- Sub-module `hold_timer`:
  - CW-bit up-counter with synchronous clear and a terminal-count compare against a runtime limit.
  - Instanced twice: hold counter (limit MIN_ON or MIN_OFF, muxed by state) and watchdog (limit TIMEOUT, saturating).
- Top level: FSM, comparators, output registers.

## Test plan
All scenarios use MIN_ON=4, MIN_OFF=3, HYST=2, TIMEOUT=20.
- **Power-up:** release reset with setpoint=40, temp=30 strobed every cycle. `state` is 0 for 3 cycles, then 1. On the next strobe: one `rele_en` pulse, `heat_on`=1, `state`=2.
- **Hysteresis:** relay on, setpoint=40.
  - temp=41 → no change.
  - temp=42 → `rele_clr` pulse, `state`=0.
  - After the hold, temp=38 → no `rele_en`; temp=37 → `rele_en`.
- **Minimum-on:** turn on, then present temp=60 immediately. `rele_clr` only after 4 cycles in ON_WAIT. Exactly one pulse.
- **Inhibit override:** assert `inhibit` on the 2nd cycle of ON_WAIT. `rele_clr` pulses next cycle, `state`=0, no further `rele_en` while `inhibit`=1 with temp=20.
- **Watchdog:**
  - Relay in ON_READY, stop `temp_valid` for 20 cycles → `sensor_fault`=1, `rele_clr` pulse, `heat_on`=0.
  - One strobe → `sensor_fault`=0 next cycle.
  - A strobe on cycle 19 → no fault.
- **Reset mid-operation:** reset in ON_READY → all outputs 0 the next cycle, no `rele_clr` pulse, MIN_OFF hold restarts.
